// File: rtl/seq_gen_pkg.sv
// Shared definitions for the serial sequence generator: FSM encoding and the default pattern.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [11:0] DEFAULT_PATTERN = 12'b1101_1001_0100;

endpackage

// File: rtl/mod_n_counter.sv
// Modulo-N up counter with enable, synchronous clear and a terminal-count (wrap) flag.
module mod_n_counter #(
  parameter int unsigned N = 12,
  parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic [W-1:0] cnt_next,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_q;

  assign cnt  = cnt_q;
  assign wrap = (cnt_q == LAST);

  // Next value is exported so the owner can register data aligned with the new index.
  always_comb begin
    cnt_next = cnt_q;
    if (clr) begin
      cnt_next = '0;
    end else if (en) begin
      cnt_next = wrap ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_next;
    end
  end

endmodule

// File: rtl/seq_gen_ctrl.sv
// Serial pattern generator: plays a latched pattern LSB-first, repeated rep times or until stop.
// Optional inter-repetition idle gap enabled by defining SEQ_GEN_CTRL_GAP_EN.
module seq_gen_ctrl
  import seq_gen_pkg::*;
#(
  parameter int unsigned PAT_W = 12,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic [CNT_W-1:0] rep_in,
  input  logic [3:0]       gap_in,
  output logic             out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IDX_W = $clog2(PAT_W);

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [CNT_W-1:0]   rep_q, rep_d;
  logic [CNT_W-1:0]   rep_cnt_q, rep_cnt_d, rep_cnt_inc;
  logic               stop_pend_q, stop_pend_d;
  logic               out_q, out_d;
  logic               rep_last;
  logic               idx_en, idx_clr, idx_wrap;
  logic [IDX_W-1:0]   idx, idx_next;

`ifdef SEQ_GEN_CTRL_GAP_EN
  logic [3:0]         gap_q, gap_d, gap_cnt_q, gap_cnt_d;
`else
  logic               unused_gap;
  assign unused_gap = ^gap_in;
`endif

  mod_n_counter #(
    .N(PAT_W),
    .W(IDX_W)
  ) u_idx (
    .clk     (clk),
    .rst     (rst),
    .en      (idx_en),
    .clr     (idx_clr),
    .cnt     (idx),
    .cnt_next(idx_next),
    .wrap    (idx_wrap)
  );

  // Saturate so an endless run (rep 0) never wraps into a false terminal count.
  assign rep_cnt_inc = (&rep_cnt_q) ? rep_cnt_q : rep_cnt_q + 1'b1;
  assign rep_last    = (rep_q != '0) && (rep_cnt_inc == rep_q);

  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    rep_d       = rep_q;
    rep_cnt_d   = rep_cnt_q;
    stop_pend_d = stop_pend_q;
    idx_en      = 1'b0;
    idx_clr     = 1'b0;
`ifdef SEQ_GEN_CTRL_GAP_EN
    gap_d       = gap_q;
    gap_cnt_d   = gap_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          pat_d       = pattern_in;
          rep_d       = rep_in;
          rep_cnt_d   = '0;
          stop_pend_d = 1'b0;
          idx_clr     = 1'b1;
          state_d     = RUN;
`ifdef SEQ_GEN_CTRL_GAP_EN
          gap_d       = gap_in;
`endif
        end
      end
      RUN: begin
        idx_en = 1'b1;
        if (stop) stop_pend_d = 1'b1;
        if (idx_wrap) begin
          rep_cnt_d = rep_cnt_inc;
          if (rep_last || stop_pend_q || stop) begin
            state_d = DONE;
`ifdef SEQ_GEN_CTRL_GAP_EN
          end else if (gap_q != '0) begin
            state_d   = GAP;
            gap_cnt_d = gap_q;
`endif
          end
        end
      end
`ifdef SEQ_GEN_CTRL_GAP_EN
      GAP: begin
        if (stop) stop_pend_d = 1'b1;
        gap_cnt_d = gap_cnt_q - 1'b1;
        if (gap_cnt_q == 4'd1) begin
          state_d = (stop_pend_q || stop) ? DONE : RUN;
        end
      end
`endif
      DONE: begin
        stop_pend_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output is registered against the index it will show next cycle.
  assign out_d = (state_d == RUN) && pat_d[idx_next];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pat_q       <= '0;
      rep_q       <= '0;
      rep_cnt_q   <= '0;
      stop_pend_q <= 1'b0;
      out_q       <= 1'b0;
`ifdef SEQ_GEN_CTRL_GAP_EN
      gap_q       <= '0;
      gap_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      rep_q       <= rep_d;
      rep_cnt_q   <= rep_cnt_d;
      stop_pend_q <= stop_pend_d;
      out_q       <= out_d;
`ifdef SEQ_GEN_CTRL_GAP_EN
      gap_q       <= gap_d;
      gap_cnt_q   <= gap_cnt_d;
`endif
    end
  end

  assign out  = out_q;
  assign busy = (state_q == RUN) || (state_q == GAP);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_seq_gen_ctrl.sv
// Bench for seq_gen_ctrl: directed scenarios plus randomized runs against a stream model.
module tb_seq_gen_ctrl;

  localparam int PW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stop;
  logic [PW-1:0] pattern_in;
  logic [7:0]    rep_in;
  logic [3:0]    gap_in;
  logic          out;
  logic          busy;
  logic          done;

  int n_tests = 0;
  int n_fail  = 0;

  seq_gen_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .pattern_in(pattern_in),
    .rep_in    (rep_in),
    .gap_in    (gap_in),
    .out       (out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".out"}, out, 1'b0);
    check({tag, ".busy"}, busy, 1'b0);
    check({tag, ".done"}, done, 1'b0);
  endtask

  // Expected per-cycle stream: each repetition is the pattern LSB-first with busy high,
  // optional gap zeros between repetitions, then a single done cycle and idle.
  task automatic run_case(input string tag, input logic [PW-1:0] p, input logic [7:0] r,
                          input logic [3:0] g, input bit has_stop, input int s_r,
                          input int s_j, input bit noise);
    logic e_out[$];
    logic e_busy[$];
    logic e_done[$];
    int   k_reps;
    int   glen;
    int   stop_idx;
    glen = 0;
`ifdef SEQ_GEN_CTRL_GAP_EN
    glen = int'(g);
`endif
    if (r == 0) k_reps = s_r + 1;
    else if (has_stop && (s_r + 1 < int'(r))) k_reps = s_r + 1;
    else k_reps = int'(r);
    stop_idx = has_stop ? s_r * (PW + glen) + s_j : -1;
    for (int rr = 0; rr < k_reps; rr++) begin
      for (int j = 0; j < PW; j++) begin
        e_out.push_back(p[j]); e_busy.push_back(1'b1); e_done.push_back(1'b0);
      end
      if (rr < k_reps - 1) begin
        for (int j = 0; j < glen; j++) begin
          e_out.push_back(1'b0); e_busy.push_back(1'b1); e_done.push_back(1'b0);
        end
      end
    end
    e_out.push_back(1'b0); e_busy.push_back(1'b0); e_done.push_back(1'b1);
    for (int j = 0; j < 2; j++) begin
      e_out.push_back(1'b0); e_busy.push_back(1'b0); e_done.push_back(1'b0);
    end

    start      = 1'b1;
    stop       = 1'b0;
    pattern_in = p;
    rep_in     = r;
    gap_in     = g;
    for (int k = 0; k < e_out.size(); k++) begin
      @(negedge clk);
      check($sformatf("%s.out[%0d]", tag, k), out, e_out[k]);
      check($sformatf("%s.busy[%0d]", tag, k), busy, e_busy[k]);
      check($sformatf("%s.done[%0d]", tag, k), done, e_done[k]);
      start = (noise && (e_busy[k] || e_done[k])) ? 1'($urandom_range(0, 1)) : 1'b0;
      stop  = (k == stop_idx);
      if (noise) begin
        pattern_in = PW'($urandom);
        rep_in     = 8'($urandom);
        gap_in     = 4'($urandom);
      end
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    logic [PW-1:0] dp;
    logic [PW-1:0] p;
    logic [7:0]    r;
    logic [3:0]    g;
    bit            hs;
    dp         = 12'b1101_1001_0100;
    rst        = 1'b1;
    start      = 1'b0;
    stop       = 1'b0;
    pattern_in = '0;
    rep_in     = '0;
    gap_in     = '0;

    repeat (2) @(negedge clk);
    check_idle("reset");

    // First edge with rst low must accept start.
    rst = 1'b0;
    run_case("single", dp, 8'd1, 4'd0, 1'b0, 0, 0, 1'b0);
    run_case("repeat3", dp, 8'd3, 4'd0, 1'b0, 0, 0, 1'b0);
    run_case("stop_mid", dp, 8'd0, 4'd0, 1'b1, 1, 5, 1'b0);
    run_case("busy_start", dp, 8'd2, 4'd0, 1'b0, 0, 0, 1'b1);
`ifdef SEQ_GEN_CTRL_GAP_EN
    run_case("gap", dp, 8'd2, 4'd3, 1'b0, 0, 0, 1'b0);
`endif

    // Reset while showing idx 7.
    start      = 1'b1;
    pattern_in = dp;
    rep_in     = 8'd0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      start = 1'b0;
      check($sformatf("rst_mid.out[%0d]", k), out, dp[k]);
      check($sformatf("rst_mid.busy[%0d]", k), busy, 1'b1);
    end
    rst = 1'b1;
    @(negedge clk);
    check_idle("rst_mid.after");
    rst = 1'b0;
    @(negedge clk);
    check_idle("rst_mid.after2");
    run_case("post_rst", dp, 8'd1, 4'd0, 1'b0, 0, 0, 1'b0);

    // start and stop together in IDLE: stop wins.
    start = 1'b1;
    stop  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_idle($sformatf("collide[%0d]", k));
    end
    start = 1'b0;
    stop  = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      p  = PW'($urandom);
      r  = 8'($urandom_range(0, 4));
      g  = 4'($urandom_range(0, 3));
      hs = (r == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      run_case($sformatf("rand%0d", i), p, r, g, hs, int'($urandom_range(0, 3)),
               int'($urandom_range(0, PW - 1)), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_gen_ctrl.md
SEQ_GEN_CTRL -- requirements
Module: seq_gen_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter PAT_W, default 12, SHALL set the pattern length in bits (range 2..16).
REQ-003 Parameter CNT_W, default 8, SHALL set the width of the repeat count and repeat counter.
REQ-004 Port clk, input, 1, SHALL be the single clock; all logic is on its rising edge.
REQ-005 Port rst, input, 1, SHALL be the synchronous active-high reset.
REQ-006 Port start, input, 1, SHALL request a run; it is accepted only in IDLE.
REQ-007 Port stop, input, 1, SHALL request a graceful stop at the end of the current repetition.
REQ-008 Port pattern_in, input, PAT_W, SHALL give the pattern; bit i is the output in step i.
REQ-009 Port rep_in, input, CNT_W, SHALL give the repetition count; 0 means run until stop.
REQ-010 Port gap_in, input, 4, SHALL give the idle cycles between repetitions (used only with REQ-031).
REQ-011 Port out, output, 1, SHALL be the registered serial sequence output.
REQ-012 Port busy, output, 1, SHALL be high in RUN and GAP.
REQ-013 Port done, output, 1, SHALL be a one-cycle pulse when a run completes.

Function
REQ-014 The FSM SHALL have four states: IDLE, RUN, GAP and DONE.
REQ-015 IDLE with start=1 and stop=0 SHALL latch pattern_in, rep_in and gap_in into internal registers and move to RUN with step index 0.
REQ-016 Later changes to pattern_in, rep_in or gap_in SHALL NOT affect a run in progress.
REQ-017 Latency SHALL be one cycle: if start is accepted at edge N, then from edge N+1 out=pattern[0] and busy=1.
REQ-018 In RUN, out SHALL equal the latched pattern[idx], and idx SHALL increment by 1 each cycle from 0 to PAT_W-1.
REQ-019 At idx=PAT_W-1, idx SHALL wrap to 0 and the repeat counter SHALL increment.
REQ-020 At the end of a repetition, the FSM SHALL go to DONE if the counter reaches a nonzero rep_q or stop is pending; otherwise it SHALL go to GAP (REQ-031) or continue in RUN at idx 0 with no bubble.
REQ-021 A stop pulse in RUN or GAP SHALL be held pending, the current repetition SHALL finish completely, and the FSM SHALL then enter DONE.
REQ-022 DONE SHALL last exactly one cycle with done=1, busy=0 and out=0, then return to IDLE.
REQ-023 start=1 while busy or in DONE SHALL be ignored and SHALL NOT be queued.
REQ-024 start and stop both high in IDLE: stop SHALL win and the FSM SHALL remain in IDLE.
REQ-025 rep_in=0 SHALL repeat indefinitely; the repeat counter SHALL saturate at all-ones and never wrap.
REQ-026 In IDLE, out=0, busy=0 and done=0.

Reset
REQ-027 rst=1 at a clock edge SHALL force IDLE, idx=0, counter=0, pending stop cleared, out=0, busy=0 and done=0, from any state including mid-run.
REQ-028 The first start is accepted on the first edge at which rst=0.
REQ-029 Reset SHALL NOT generate a done pulse.

Configuration
REQ-030 Macro SEQ_GEN_CTRL_GAP_EN SHALL control the inter-repetition gap feature.
REQ-031 With the macro defined: after each non-final repetition, if gap_q is nonzero, the FSM SHALL spend exactly gap_q cycles in GAP with out=0 and busy=1, then return to RUN at idx 0; gap_q=0 SHALL skip GAP.
REQ-032 Without the macro: the GAP state and its counter SHALL be absent, gap_in SHALL remain present but be ignored, and repetitions SHALL be back-to-back.

Structure
REQ-033 Package seq_gen_pkg SHALL hold the state encoding constants (IDLE=2'd0, RUN=2'd1, GAP=2'd2, DONE=2'd3) and DEFAULT_PATTERN=12'b1101_1001_0100.
REQ-034 The step index SHALL be a sub-module mod_n_counter (modulus PAT_W, enable, synchronous clear, wrap flag); the repeat and gap counters SHALL stay inline.

Verification
REQ-035 Single run: pattern=DEFAULT_PATTERN, rep_in=1, start pulse -> out = 0,0,1,0,1,0,0,1,1,0,1,1 on cycles 1-12, then done=1 on cycle 13, then IDLE.
REQ-036 Repeat: rep_in=3, no gap -> 36 contiguous pattern bits with busy=1 throughout, then a single done pulse.
REQ-037 Stop mid-run: rep_in=0, stop at idx 5 of the 2nd repetition -> the 2nd repetition completes (24 bits total), then done.
REQ-038 Reset mid-run: rst asserted at idx 7 -> the next cycle has out=0, busy=0 and no done pulse; a new start gives pattern[0] again.
REQ-039 Collisions: start during busy is ignored; start and stop together in IDLE -> stays IDLE.
REQ-040 Gap (macro defined): rep_in=2, gap_in=3 -> 12 bits, 3 zero cycles with busy=1, 12 bits, done.
